// File: rtl/ads1675_pkg.sv
// ads1675_pkg: shared types and constants for the ADS1675 acquisition controller.
//   acq_state_e : controller state encoding (IDLE, PWRUP, CFG, RUN, DRAIN)
//   LVDS_SEL / CLK_SEL_INT / LL_CFG_OFF : fixed ADS1675 strap-pin levels
//   cnt_w(n)    : register width needed to hold the values 0..n-1 (minimum 1)
package ads1675_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PWRUP,
    CFG,
    RUN,
    DRAIN
  } acq_state_e;

  localparam logic LVDS_SEL    = 1'b1;
  localparam logic CLK_SEL_INT = 1'b1;
  localparam logic LL_CFG_OFF  = 1'b0;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ads1675_acq_ctrl_if.sv
// ads1675_acq_ctrl_if: AXI4-Stream sample bus from the acquisition controller.
//   tvalid/tlast/tdata driven by the master, tready driven by the slave.
//   master modport : controller side; slave modport : DMA / sink side.
interface ads1675_acq_ctrl_if #(
  parameter int unsigned DW = 32
) ();

  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic signed [DW-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);

endinterface

// File: rtl/ads1675_axis_pkt.sv
// ads1675_axis_pkt: single-entry AXIS output register with packet sample counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clears overflow flag and sample counter (held while controller idle)
//   load_en    : samples may be accepted this cycle
//   s_valid    : new-sample strobe, s_data : sample
//   m_axis     : AXIS master (tlast on every LAST-th loaded sample)
//   cnt_zero   : sample counter sits at a packet boundary
//   overflow   : sticky, a sample arrived while the register was full and stalled
module ads1675_axis_pkt
  import ads1675_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned LAST = 20000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_en,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_data,
  ads1675_acq_ctrl_if.master   m_axis,
  output logic                 cnt_zero,
  output logic                 overflow
);

  localparam int unsigned CNT_W = cnt_w(LAST);

  logic                 tvalid_q;
  logic                 tlast_q;
  logic signed [DW-1:0] tdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ovf_q;
  logic                 take;
  logic                 can_load;

  assign take     = load_en && s_valid;
  // A beat leaving this cycle frees the register, so accept+load has no bubble.
  assign can_load = !tvalid_q || m_axis.tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (take && can_load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= s_data;
        tlast_q  <= (cnt_q == CNT_W'(LAST - 1));
        cnt_q    <= (cnt_q == CNT_W'(LAST - 1)) ? '0 : cnt_q + 1'b1;
      end else if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      if (take && !can_load) begin
        ovf_q <= 1'b1;
      end
      if (clr) begin
        ovf_q <= 1'b0;
        cnt_q <= '0;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;
  assign cnt_zero      = (cnt_q == '0);
  assign overflow      = ovf_q;

endmodule

// File: rtl/ads1675_acq_ctrl.sv
// ads1675_acq_ctrl: ADS1675 power-up / configuration / START sequencer that gates
// deserialised samples into a packetised AXI4-Stream.
//   sclk, rst_n        : clock, asynchronous active-low reset
//   external_en        : 1 = acquire, 0 = stop at next packet boundary
//   cfg_dr, cfg_fpath  : configuration latched when leaving IDLE
//   s_valid, s_data    : sample strobe and data from the LVDS receiver
//   dr, fpath, ll_cfg, lvds, clk_sel, cs_n, start, pown : ADS1675 pins
//   m_axis             : AXIS master (TLAST every LAST samples)
//   busy               : controller not idle
//   overflow           : sticky sample-drop flag, cleared in IDLE
// Build option: define ADS1675_DROP_EN to discard the first DROP_N samples after
// START (sinc filter settling).
module ads1675_acq_ctrl
  import ads1675_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned LAST      = 20000,
  parameter int unsigned PWRUP_CYC = 4096,
  parameter int unsigned CFG_CYC   = 64,
  parameter int unsigned DROP_N    = 16
) (
  input  logic                 sclk,
  input  logic                 rst_n,
  input  logic                 external_en,
  input  logic [2:0]           cfg_dr,
  input  logic                 cfg_fpath,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_data,
  output logic [2:0]           dr,
  output logic                 fpath,
  output logic                 ll_cfg,
  output logic                 lvds,
  output logic                 clk_sel,
  output logic                 cs_n,
  output logic                 start,
  output logic                 pown,
  ads1675_acq_ctrl_if.master   m_axis,
  output logic                 busy,
  output logic                 overflow
);

`ifdef ADS1675_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  localparam int unsigned DROP_LIM = DROP_EN ? DROP_N : 0;
  localparam int unsigned DROP_W   = cnt_w(DROP_LIM + 1);
  localparam int unsigned TMR_W    = cnt_w((PWRUP_CYC > CFG_CYC) ? PWRUP_CYC : CFG_CYC);

  acq_state_e        state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [DROP_W-1:0] drop_q;
  logic              pown_q;
  logic              start_q;
  logic              cs_n_q;
  logic [2:0]        dr_q;
  logic              fpath_q;

  logic              cnt_zero;
  logic              drop_now;
  logic              load_en;
  logic              drain_done;
  logic              streaming;

  assign streaming = (state_q == RUN) || (state_q == DRAIN);
  assign drop_now  = streaming && s_valid && (drop_q != '0);
  // While draining, the counter returning to 0 means the tlast sample is already
  // loaded (or none of this packet was), so nothing further may enter.
  assign load_en   = !drop_now && ((state_q == RUN) || ((state_q == DRAIN) && !cnt_zero));
  assign drain_done = (m_axis.tvalid && m_axis.tlast && m_axis.tready) ||
                      (cnt_zero && !m_axis.tvalid);

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      drop_q  <= '0;
      pown_q  <= 1'b0;
      start_q <= 1'b0;
      cs_n_q  <= 1'b1;
      dr_q    <= '0;
      fpath_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (external_en) begin
            state_q <= PWRUP;
            pown_q  <= 1'b1;
            dr_q    <= cfg_dr;
            fpath_q <= cfg_fpath;
            timer_q <= '0;
          end
        end
        PWRUP, CFG: begin
          if (!external_en) begin
            state_q <= IDLE;
            pown_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            dr_q    <= '0;
            fpath_q <= 1'b0;
          end else if (state_q == PWRUP && timer_q == TMR_W'(PWRUP_CYC - 1)) begin
            state_q <= CFG;
            cs_n_q  <= 1'b0;
            timer_q <= '0;
          end else if (state_q == CFG && timer_q == TMR_W'(CFG_CYC - 1)) begin
            state_q <= RUN;
            start_q <= 1'b1;
            drop_q  <= DROP_W'(DROP_LIM);
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        RUN: begin
          if (drop_now) drop_q <= drop_q - 1'b1;
          if (!external_en) state_q <= DRAIN;
        end
        DRAIN: begin
          if (drop_now) drop_q <= drop_q - 1'b1;
          if (drain_done) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            cs_n_q  <= 1'b1;
            pown_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ads1675_axis_pkt #(
    .DW   (DW),
    .LAST (LAST)
  ) u_pkt (
    .clk      (sclk),
    .rst_n    (rst_n),
    .clr      (state_q == IDLE),
    .load_en  (load_en),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .m_axis   (m_axis),
    .cnt_zero (cnt_zero),
    .overflow (overflow)
  );

  assign dr      = dr_q;
  assign fpath   = fpath_q;
  assign ll_cfg  = LL_CFG_OFF;
  assign lvds    = LVDS_SEL;
  assign clk_sel = CLK_SEL_INT;
  assign cs_n    = cs_n_q;
  assign start   = start_q;
  assign pown    = pown_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ads1675_acq_ctrl.sv
// tb_ads1675_acq_ctrl: directed self-checking bench for ads1675_acq_ctrl
// (PWRUP_CYC=8, CFG_CYC=4, LAST=4, DROP_N=2). Adapts expectations when
// ADS1675_DROP_EN is defined.
module tb_ads1675_acq_ctrl;

  localparam int DW = 32;
  localparam int LAST = 4;
  localparam int PW = 8;
  localparam int CC = 4;
  localparam int DN = 2;
`ifdef ADS1675_DROP_EN
  localparam int FIRST = DN + 1;
`else
  localparam int FIRST = 1;
`endif

  logic                 sclk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic [2:0]           cfg_dr = '0;
  logic                 cfg_fpath = 1'b0;
  logic                 s_valid = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic [2:0]           dr;
  logic                 fpath, ll_cfg, lvds, clk_sel, cs_n, start, pown, busy, overflow;

  int n_tests = 0;
  int n_fail  = 0;

  ads1675_acq_ctrl_if #(.DW(DW)) axis ();

  ads1675_acq_ctrl #(
    .DW(DW), .LAST(LAST), .PWRUP_CYC(PW), .CFG_CYC(CC), .DROP_N(DN)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .external_en(en), .cfg_dr(cfg_dr), .cfg_fpath(cfg_fpath),
    .s_valid(s_valid), .s_data(s_data), .dr(dr), .fpath(fpath), .ll_cfg(ll_cfg),
    .lvds(lvds), .clk_sel(clk_sel), .cs_n(cs_n), .start(start), .pown(pown),
    .m_axis(axis), .busy(busy), .overflow(overflow)
  );

  always #5 sclk = ~sclk;

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic start_run(input bit flush);
    en = 1'b1;
    repeat (1 + PW + CC) step();
    if (flush) begin
      for (int k = 1; k < FIRST; k++) begin
        s_valid = 1'b1; s_data = -k; step();
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic stop_run();
    axis.tready = 1'b1;
    en = 1'b0; s_valid = 1'b0;
    step();
    for (int k = 0; k < 30 && busy; k++) begin
      s_valid = 1'b1; s_data = 100 + k; step();
    end
    s_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stop_run: busy=%b required 0 within 30 cycles", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; axis.tready = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({pown, start, cs_n, dr, fpath, busy} !== {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_pins: pown=%b start=%b cs_n=%b dr=%b fpath=%b busy=%b required 0 0 1 000 0 0",
                         pown, start, cs_n, dr, fpath, busy);
    end
    n_tests++;
    if ({axis.tvalid, axis.tlast, axis.tdata, overflow} !== {1'b0, 1'b0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_axis: tvalid=%b tlast=%b tdata=%0h ovf=%b required 0 0 0 0",
                         axis.tvalid, axis.tlast, axis.tdata, overflow);
    end
    n_tests++;
    if ({lvds, clk_sel, ll_cfg} !== 3'b110) begin
      n_fail++; $display("FAIL const_pins: lvds/clk_sel/ll_cfg=%b required 110", {lvds, clk_sel, ll_cfg});
    end
    @(negedge sclk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_powerup();
    cfg_dr = 3'b101; cfg_fpath = 1'b1; en = 1'b1;
    step();
    cfg_dr = 3'b010; cfg_fpath = 1'b0;
    n_tests++;
    if ({pown, busy, cs_n, dr, fpath} !== {1'b1, 1'b1, 1'b1, 3'b101, 1'b1}) begin
      n_fail++; $display("FAIL pwrup_t1: pown=%b busy=%b cs_n=%b dr=%b fpath=%b required 1 1 1 101 1",
                         pown, busy, cs_n, dr, fpath);
    end
    repeat (PW - 1) step();
    n_tests++;
    if (cs_n !== 1'b1) begin n_fail++; $display("FAIL cfg_t8: cs_n=%b required 1", cs_n); end
    step();
    n_tests++;
    if ({cs_n, start} !== 2'b00) begin
      n_fail++; $display("FAIL cfg_t9: cs_n=%b start=%b required 0 0", cs_n, start);
    end
    repeat (CC - 1) step();
    n_tests++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL start_t12: start=%b required 0", start); end
    step();
    n_tests++;
    if ({start, cs_n, pown, dr, fpath} !== {1'b1, 1'b0, 1'b1, 3'b101, 1'b1}) begin
      n_fail++; $display("FAIL start_t13: start=%b cs_n=%b pown=%b dr=%b fpath=%b required 1 0 1 101 1",
                         start, cs_n, pown, dr, fpath);
    end
    stop_run();
    n_tests++;
    if ({pown, start, cs_n} !== 3'b001) begin
      n_fail++; $display("FAIL pwrdown: pown=%b start=%b cs_n=%b required 0 0 1", pown, start, cs_n);
    end
  endtask

  task automatic test_back_to_back();
    axis.tready = 1'b1;
    start_run(1'b1);
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = i; step();
      n_tests++;
      if ({axis.tvalid, axis.tlast, axis.tdata} !== {1'b1, (i % 4 == 0), 32'(i)}) begin
        n_fail++; $display("FAIL stream_beat%0d: tvalid=%b tlast=%b tdata=%0d required 1 %b %0d",
                           i, axis.tvalid, axis.tlast, axis.tdata, (i % 4 == 0), i);
      end
    end
    s_valid = 1'b0; step();
    n_tests++;
    if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL stream_empty: tvalid=%b required 0", axis.tvalid); end
    stop_run();
  endtask

  task automatic test_backpressure();
    axis.tready = 1'b1;
    start_run(1'b1);
    s_valid = 1'b1; s_data = 1; step();
    axis.tready = 1'b0;
    s_data = 2; step();
    n_tests++;
    if ({axis.tvalid, axis.tdata, overflow} !== {1'b1, 32'd1, 1'b1}) begin
      n_fail++; $display("FAIL bp_hold2: tvalid=%b tdata=%0d ovf=%b required 1 1 1", axis.tvalid, axis.tdata, overflow);
    end
    s_data = 3; step();
    n_tests++;
    if ({axis.tvalid, axis.tdata} !== {1'b1, 32'd1}) begin
      n_fail++; $display("FAIL bp_hold3: tvalid=%b tdata=%0d required 1 1", axis.tvalid, axis.tdata);
    end
    s_valid = 1'b0; axis.tready = 1'b1; step();
    n_tests++;
    if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL bp_release: tvalid=%b required 0", axis.tvalid); end
    // counter stayed at 1, so the packet closes on the third further sample
    for (int i = 4; i <= 6; i++) begin
      s_valid = 1'b1; s_data = i; step();
      n_tests++;
      if ({axis.tvalid, axis.tlast, axis.tdata} !== {1'b1, (i == 6), 32'(i)}) begin
        n_fail++; $display("FAIL bp_beat%0d: tvalid=%b tlast=%b tdata=%0d required 1 %b %0d",
                           i, axis.tvalid, axis.tlast, axis.tdata, (i == 6), i);
      end
    end
    s_valid = 1'b0; step();
    n_tests++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: overflow=%b required 1", overflow); end
    stop_run();
    step();
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: overflow=%b required 0", overflow); end
  endtask

  task automatic test_drain();
    axis.tready = 1'b1;
    start_run(1'b1);
    s_valid = 1'b1; s_data = 1; step();
    s_data = 2; step();
    s_valid = 1'b0; en = 1'b0; step();
    n_tests++;
    if ({busy, axis.tvalid} !== 2'b10) begin
      n_fail++; $display("FAIL drain_enter: busy=%b tvalid=%b required 1 0", busy, axis.tvalid);
    end
    for (int i = 3; i <= 4; i++) begin
      s_valid = 1'b1; s_data = i; step();
      n_tests++;
      if ({axis.tvalid, axis.tlast, axis.tdata} !== {1'b1, (i == 4), 32'(i)}) begin
        n_fail++; $display("FAIL drain_beat%0d: tvalid=%b tlast=%b tdata=%0d required 1 %b %0d",
                           i, axis.tvalid, axis.tlast, axis.tdata, (i == 4), i);
      end
    end
    s_data = 5; step();
    s_valid = 1'b0;
    n_tests++;
    if ({axis.tvalid, busy, pown, start, cs_n} !== 5'b00001) begin
      n_fail++; $display("FAIL drain_exit: tvalid=%b busy=%b pown=%b start=%b cs_n=%b required 0 0 0 0 1",
                         axis.tvalid, busy, pown, start, cs_n);
    end
  endtask

  task automatic test_abort();
    axis.tready = 1'b1;
    cfg_dr = 3'b111; cfg_fpath = 1'b1; en = 1'b1;
    repeat (3) step();
    en = 1'b0; s_valid = 1'b1; s_data = 9; step();
    n_tests++;
    if ({busy, pown, cs_n, dr, fpath, axis.tvalid} !== {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort: busy=%b pown=%b cs_n=%b dr=%b fpath=%b tvalid=%b required 0 0 1 000 0 0",
                         busy, pown, cs_n, dr, fpath, axis.tvalid);
    end
    repeat (3) step();
    s_valid = 1'b0;
    n_tests++;
    if ({busy, axis.tvalid} !== 2'b00) begin
      n_fail++; $display("FAIL idle_ignore: busy=%b tvalid=%b required 0 0", busy, axis.tvalid);
    end
  endtask

  task automatic test_drop();
    axis.tready = 1'b1;
    start_run(1'b0);
    for (int i = 1; i <= 6; i++) begin
      s_valid = 1'b1; s_data = i; step();
      n_tests++;
      if (i < FIRST) begin
        if (axis.tvalid !== 1'b0) begin
          n_fail++; $display("FAIL drop_strobe%0d: tvalid=%b required 0", i, axis.tvalid);
        end
      end else if ({axis.tvalid, axis.tlast, axis.tdata} !== {1'b1, ((i - FIRST + 1) % 4 == 0), 32'(i)}) begin
        n_fail++; $display("FAIL drop_beat%0d: tvalid=%b tlast=%b tdata=%0d required 1 %b %0d",
                           i, axis.tvalid, axis.tlast, axis.tdata, ((i - FIRST + 1) % 4 == 0), i);
      end
    end
    s_valid = 1'b0;
    stop_run();
  endtask

  task automatic test_async_reset();
    axis.tready = 1'b0;
    start_run(1'b1);
    s_valid = 1'b1; s_data = 1; step();
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0; en = 1'b0;
    #1;
    n_tests++;
    if ({axis.tvalid, pown, start, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset: tvalid=%b pown=%b start=%b busy=%b required 0 0 0 0",
                         axis.tvalid, pown, start, busy);
    end
    @(negedge sclk); rst_n = 1'b1; axis.tready = 1'b1;
    step();
    n_tests++;
    if ({axis.tvalid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset: tvalid=%b busy=%b required 0 0", axis.tvalid, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis.tready = 1'b1;
    test_reset();
    test_powerup();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_abort();
    test_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
